// File: rtl/edge_detect_pkg.sv
`default_nettype none
// ============================================================================
//  edge_detect_pkg
//  Mode encodings and helper functions shared by the edge detector files.
//  Rev 1.0
// ============================================================================
package edge_detect_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_POS  = 2'b01;
  localparam logic [1:0] MODE_NEG  = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Debounce counter must hold 0..DEBOUNCE-1 and never collapse to zero width.
  function automatic int dcnt_width(input int debounce);
    if (debounce <= 2) return 1;
    return $clog2(debounce);
  endfunction

  function automatic logic mode_rise_en(input logic [1:0] mode);
    return (mode == MODE_POS) || (mode == MODE_BOTH);
  endfunction

  function automatic logic mode_fall_en(input logic [1:0] mode);
    return (mode == MODE_NEG) || (mode == MODE_BOTH);
  endfunction

endpackage : edge_detect_pkg
`default_nettype wire

// File: rtl/edge_chan.sv
`default_nettype none
// ============================================================================
//  edge_chan
//  One channel: synchroniser, debounce, edge pulses, sticky flag, edge counter.
//  Rev 1.0
// ============================================================================
module edge_chan
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 3,
  parameter int CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_din,
  input  logic [1:0]       i_mode,
  input  logic             i_clr,
  output logic             o_q,
  output logic             o_pos,
  output logic             o_neg,
  output logic             o_edge,
  output logic             o_flag,
  output logic [CNT_W-1:0] o_cnt
);

  localparam int                DCNT_W     = dcnt_width(DEBOUNCE);
  localparam logic [DCNT_W-1:0] c_DCNT_MAX = DCNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DCNT_W-1:0]      r_dcnt;
  logic                   r_q;
  logic                   r_pos;
  logic                   r_neg;
  logic                   r_flag;
  logic [CNT_W-1:0]       r_cnt;

  logic                   w_sync_out;
  logic                   w_edge;
  logic                   w_flag_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
    end
  end

  // Q only follows the synchronised input after DEBOUNCE consecutive mismatches.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_dcnt <= '0;
      r_q    <= 1'b0;
      r_pos  <= 1'b0;
      r_neg  <= 1'b0;
    end else begin
      r_pos <= 1'b0;
      r_neg <= 1'b0;
      if (w_sync_out == r_q) begin
        r_dcnt <= '0;
      end else if (r_dcnt == c_DCNT_MAX) begin
        r_dcnt <= '0;
        r_q    <= w_sync_out;
        r_pos  <= w_sync_out;
        r_neg  <= ~w_sync_out;
      end else begin
        r_dcnt <= r_dcnt + DCNT_W'(1);
      end
    end
  end

  assign w_edge = (r_pos & mode_rise_en(i_mode)) | (r_neg & mode_fall_en(i_mode));

  always_comb begin
    w_flag_nxt = w_edge | (r_flag & ~i_clr);
    w_cnt_nxt  = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = CNT_W'(w_edge);
    end else if (w_edge && (r_cnt != c_CNT_MAX)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_flag <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_flag <= w_flag_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign o_q    = r_q;
  assign o_pos  = r_pos;
  assign o_neg  = r_neg;
  assign o_edge = w_edge;
  assign o_flag = r_flag;
  assign o_cnt  = r_cnt;

endmodule : edge_chan
`default_nettype wire

// File: rtl/edge_detect_multi.sv
`default_nettype none
// ============================================================================
//  edge_detect_multi
//  WIDTH independent debounced edge detector channels with flags and counters.
//  Rev 1.0
// ============================================================================
module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 3,
  parameter int CNT_W       = 8
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [WIDTH-1:0]       Din,
  input  logic [2*WIDTH-1:0]     Mode,
  input  logic [WIDTH-1:0]       Clr,
  output logic [WIDTH-1:0]       Q,
  output logic [WIDTH-1:0]       Pos_pulse,
  output logic [WIDTH-1:0]       Neg_pulse,
  output logic [WIDTH-1:0]       Edge_pulse,
  output logic [WIDTH-1:0]       Event_flag,
  output logic [WIDTH*CNT_W-1:0] Edge_cnt
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE    (DEBOUNCE),
      .CNT_W       (CNT_W)
    ) u_chan (
      .i_clk   (Clk),
      .i_rst_n (Rst_n),
      .i_din   (Din[gi]),
      .i_mode  (Mode[2*gi +: 2]),
      .i_clr   (Clr[gi]),
      .o_q     (Q[gi]),
      .o_pos   (Pos_pulse[gi]),
      .o_neg   (Neg_pulse[gi]),
      .o_edge  (Edge_pulse[gi]),
      .o_flag  (Event_flag[gi]),
      .o_cnt   (Edge_cnt[CNT_W*gi +: CNT_W])
    );
  end : g_chan

endmodule : edge_detect_multi
`default_nettype wire

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
Parametrised multi-channel edge detector. It is the successor to the gate-level D latch used in the edge-detection work.
- Each channel synchronises an asynchronous input, debounces it, and produces single-cycle rising/falling pulses.
- Each channel has a mode-qualified event pulse, a sticky event flag and a saturating edge counter.
- It sits between raw external pins (buttons, sensor strobes) and control logic that needs clean one-cycle events.

Parameters:
- WIDTH, 4: number of independent channels (>=1).
- SYNC_STAGES, 2: flops in each input synchroniser chain (>=2).
- DEBOUNCE, 3: consecutive cycles the synchronised input must differ from Q before Q changes (>=1).
- CNT_W, 8: width of each per-channel edge counter (>=1).

Ports:
- Clk  input  1  single clock; every flop is rising-edge on Clk.
- Rst_n  input  1  synchronous, active-low reset.
- Din  input  WIDTH  asynchronous raw inputs, one bit per channel.
- Mode  input  2*WIDTH  per-channel mode; bits [2i+1:2i] belong to channel i. 00 = off, 01 = rising, 10 = falling, 11 = both.
- Clr  input  WIDTH  per-channel clear of Event_flag and Edge_cnt.
- Q  output  WIDTH  debounced, synchronised level.
- Pos_pulse  output  WIDTH  one-cycle pulse on each debounced rising edge (ignores Mode).
- Neg_pulse  output  WIDTH  one-cycle pulse on each debounced falling edge (ignores Mode).
- Edge_pulse  output  WIDTH  (Pos_pulse & Mode[2i]) | (Neg_pulse & Mode[2i+1]).
- Event_flag  output  WIDTH  sticky; set by Edge_pulse, cleared by Clr.
- Edge_cnt  output  WIDTH*CNT_W  per-channel count of Edge_pulse; channel i occupies bits [CNT_W*(i+1)-1 : CNT_W*i].

Behaviour:
- Reset: Rst_n sampled low at a Clk edge zeroes all state.
  - State cleared: sync chains, debounce counters, Q, Pos_pulse, Neg_pulse, Edge_pulse, Event_flag, Edge_cnt.
  - Reset mid-debounce discards the partial count.
  - If Din is held 1 through reset, a rising edge is reported after the normal latency once reset is released.
- Synchroniser: Din[i] shifts through SYNC_STAGES flops. The last stage is sync_out[i].
- Debounce, per channel, with counter dcnt of width max(1, clog2(DEBOUNCE)):
  - sync_out == Q: dcnt <= 0.
  - sync_out != Q and dcnt < DEBOUNCE-1: dcnt <= dcnt+1.
  - sync_out != Q and dcnt == DEBOUNCE-1: Q <= sync_out and dcnt <= 0. In the same edge, Pos_pulse <= sync_out and Neg_pulse <= ~sync_out.
  - Any mismatch run shorter than DEBOUNCE cycles is discarded with no pulse.
- Latency: Q, Pos_pulse and Neg_pulse change at the (SYNC_STAGES+DEBOUNCE)-th Clk edge, counting the edge that first samples the new Din as edge 1. With defaults this is edge 5.
- Pulses: Pos_pulse and Neg_pulse are registered and last exactly one cycle. They are mutually exclusive, and are high in the same cycle Q first shows the new value.
- Edge_pulse: combinational from the registered pulses and the current Mode. A Mode change therefore takes effect immediately and is never retroactive.
- Event_flag: next = Edge_pulse | (flag & ~Clr). If Edge_pulse and Clr coincide, set wins and the flag is 1.
- Edge_cnt: on Clr, it loads Edge_pulse (0 or 1). Otherwise it increments on Edge_pulse and saturates at 2^CNT_W-1 (no wrap).
- Channels are fully independent. There is no cross-channel arbitration.

Decomposition:
- Shared package edge_detect_pkg holds:
  - mode constants MODE_OFF=2'b00, MODE_POS=2'b01, MODE_NEG=2'b10, MODE_BOTH=2'b11;
  - the debounce-counter width function.
- One sub-module, edge_chan, implements a single channel: synchroniser, debounce, pulses, flag and counter.
- The top level instantiates WIDTH copies of edge_chan in a generate loop and slices the Mode and Edge_cnt buses.

Test Plan:
1. Reset with Din=4'b0000 held low for 2 cycles, then released -> all outputs 0. With Din held at 0, no pulse appears over 20 cycles.
2. Din[0] 0->1, Mode[1:0]=01, default parameters -> Q[0] and Pos_pulse[0] go high at edge 5 after sampling, Pos_pulse[0] lasts 1 cycle, Edge_pulse[0]=1, Event_flag[0]=1, Edge_cnt[0]=1.
3. Glitch: Din[1] high for 2 cycles, then low, Mode=11 -> Q[1] stays 0, no pulses, Edge_cnt[1]=0.
4. Mode[5:4]=10 on channel 2, Din[2] toggled 0->1->0 with 10-cycle spacing -> Pos_pulse[2] and Neg_pulse[2] each pulse once, and Edge_pulse[2] fires only on the fall. Edge_cnt[2]=1.
5. CNT_W=2, Mode=11, 5 debounced edges on channel 3 -> Edge_cnt[3] reads 1, 2, 3, 3, 3 (saturates).
6. Clr[0] asserted in the same cycle as Edge_pulse[0] -> Event_flag[0]=1, Edge_cnt[0]=1. Clr[0] alone on the next cycle -> flag 0, count 0.
